// File: rtl/chess_pkg.sv
// Shared chess constants: piece codes, centipawn values, scorer FSM states and register map.
package chess_pkg;

  localparam logic signed [7:0] EMPTY    = 8'sd0;
  localparam logic signed [7:0] WPAWN0   = 8'sd1;
  localparam logic signed [7:0] WPAWN7   = 8'sd8;
  localparam logic signed [7:0] WROOK0   = 8'sd9;
  localparam logic signed [7:0] WROOK9   = 8'sd18;
  localparam logic signed [7:0] WKNIGHT0 = 8'sd19;
  localparam logic signed [7:0] WKNIGHT9 = 8'sd28;
  localparam logic signed [7:0] WBISHOP0 = 8'sd29;
  localparam logic signed [7:0] WBISHOP9 = 8'sd38;
  localparam logic signed [7:0] WQUEEN   = 8'sd39;
  localparam logic signed [7:0] WQUEEN8  = 8'sd47;
  localparam logic signed [7:0] WKING    = 8'sd48;
  localparam logic signed [7:0] BPAWN0   = -8'sd1;
  localparam logic signed [7:0] BROOK0   = -8'sd9;
  localparam logic signed [7:0] BKNIGHT0 = -8'sd19;
  localparam logic signed [7:0] BBISHOP0 = -8'sd29;
  localparam logic signed [7:0] BQUEEN   = -8'sd39;
  localparam logic signed [7:0] BKING    = -8'sd48;

  localparam logic signed [15:0] VAL_PAWN   = 16'sd100;
  localparam logic signed [15:0] VAL_ROOK   = 16'sd500;
  localparam logic signed [15:0] VAL_KNIGHT = 16'sd320;
  localparam logic signed [15:0] VAL_BISHOP = 16'sd330;
  localparam logic signed [15:0] VAL_QUEEN  = 16'sd900;
  localparam logic signed [15:0] VAL_KING   = 16'sd0;

  typedef enum logic [2:0] {
    StIdle,
    StRdReq,
    StRdWait,
    StWrReq,
    StNext,
    StDone
  } state_e;

  localparam logic [3:0] REG_START       = 4'd0;
  localparam logic [3:0] REG_BOARD_BASE  = 4'd1;
  localparam logic [3:0] REG_COUNT       = 4'd2;
  localparam logic [3:0] REG_RESULT_BASE = 4'd3;
  localparam logic [3:0] REG_SIDE        = 4'd4;
  localparam logic [3:0] REG_BEST_SCORE  = 4'd5;
  localparam logic [3:0] REG_BEST_IDX    = 4'd6;

endpackage

// File: rtl/piece_value.sv
// Combinational piece code -> signed centipawn value; black (negative) codes give negative values.
module piece_value
  import chess_pkg::*;
(
  input  logic signed [7:0]  i_code,
  output logic signed [15:0] o_value
);

  logic [7:0]         w_mag;
  logic signed [15:0] w_abs_val;

  always_comb begin
    w_mag     = i_code[7] ? (~i_code + 8'd1) : i_code;
    w_abs_val = 16'sd0;
    // -128 folds to magnitude 128, which lands in the "no piece" range
    if (w_mag >= $unsigned(WPAWN0) && w_mag <= $unsigned(WPAWN7)) begin
      w_abs_val = VAL_PAWN;
    end else if (w_mag >= $unsigned(WROOK0) && w_mag <= $unsigned(WROOK9)) begin
      w_abs_val = VAL_ROOK;
    end else if (w_mag >= $unsigned(WKNIGHT0) && w_mag <= $unsigned(WKNIGHT9)) begin
      w_abs_val = VAL_KNIGHT;
    end else if (w_mag >= $unsigned(WBISHOP0) && w_mag <= $unsigned(WBISHOP9)) begin
      w_abs_val = VAL_BISHOP;
    end else if (w_mag >= $unsigned(WQUEEN) && w_mag <= $unsigned(WQUEEN8)) begin
      w_abs_val = VAL_QUEEN;
    end else if (w_mag == $unsigned(WKING)) begin
      w_abs_val = VAL_KING;
    end
    o_value = i_code[7] ? -w_abs_val : w_abs_val;
  end

endmodule

// File: rtl/board_scorer.sv
// Scans N 64-byte boards over a byte-wide Avalon master, writes one signed score word per board
// and tracks the best board for the selected side; configured through a small Avalon slave.
module board_scorer
  import chess_pkg::*;
#(
  parameter int unsigned MAX_BOARDS = 64,
  parameter int unsigned SQUARES    = 64
) (
  input  logic        clk,
  input  logic        rst,
  output logic        slave_waitrequest,
  input  logic [3:0]  slave_address,
  input  logic        slave_read,
  output logic [31:0] slave_readdata,
  input  logic        slave_write,
  input  logic [31:0] slave_writedata,
  input  logic        master_waitrequest,
  output logic [31:0] master_address,
  output logic        master_read,
  input  logic [31:0] master_readdata,
  input  logic        master_readdatavalid,
  output logic        master_write,
  output logic [31:0] master_writedata
);

  state_e             r_state, w_state_d;
  logic [31:0]        r_board_base, r_result_base, r_best_idx;
  logic [6:0]         r_count, r_b;
  logic [5:0]         r_sq;
  logic               r_side;
  logic signed [31:0] r_acc, r_best_score;

  logic               w_idle_like, w_wr_ok, w_start, w_better, w_unused_rdata;
  logic signed [15:0] w_value;

  assign w_unused_rdata = ^master_readdata[31:8];

  piece_value u_piece_value (
    .i_code  (master_readdata[7:0]),
    .o_value (w_value)
  );

  assign w_idle_like = (r_state == StIdle) || (r_state == StDone);
  // Start reads stall until the scan completes; config writes stall while busy
  assign slave_waitrequest = rst || (slave_write && !w_idle_like) ||
                             (slave_read && slave_address == REG_START && r_state != StDone);
  assign w_wr_ok  = slave_write && !slave_waitrequest;
  assign w_start  = w_wr_ok && slave_address == REG_START;
  assign w_better = (r_b == 7'd0) || (r_side ? (r_acc < r_best_score) : (r_acc > r_best_score));

  always_comb begin
    slave_readdata = 32'h0;
    if (slave_read && !slave_waitrequest) begin
      case (slave_address)
        REG_START:       slave_readdata = r_best_idx;
        REG_BOARD_BASE:  slave_readdata = r_board_base;
        REG_COUNT:       slave_readdata = 32'(r_count);
        REG_RESULT_BASE: slave_readdata = r_result_base;
        REG_SIDE:        slave_readdata = {31'h0, r_side};
        REG_BEST_SCORE:  slave_readdata = r_best_score;
        REG_BEST_IDX:    slave_readdata = r_best_idx;
        default:         slave_readdata = 32'h0;
      endcase
    end
  end

  always_comb begin
    master_read      = (r_state == StRdReq);
    master_write     = (r_state == StWrReq);
    master_address   = 32'h0;
    master_writedata = 32'h0;
    if (r_state == StRdReq) begin
      master_address = r_board_base + 32'(r_b) * SQUARES + 32'(r_sq);
    end else if (r_state == StWrReq) begin
      master_address   = r_result_base + {23'h0, r_b, 2'b00};
      master_writedata = r_acc;
    end
  end

  always_comb begin
    w_state_d = r_state;
    case (r_state)
      StIdle, StDone: if (w_start) w_state_d = (r_count == 7'd0) ? StDone : StRdReq;
      StRdReq:        if (!master_waitrequest) w_state_d = StRdWait;
      StRdWait: begin
        if (master_readdatavalid) w_state_d = (r_sq == 6'd63) ? StWrReq : StRdReq;
      end
      StWrReq:        if (!master_waitrequest) w_state_d = StNext;
      StNext:         w_state_d = (r_b + 7'd1 == r_count) ? StDone : StRdReq;
      default:        w_state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= StIdle;
    end else begin
      r_state <= w_state_d;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_board_base  <= 32'h0;
      r_result_base <= 32'h0;
      r_count       <= 7'd0;
      r_side        <= 1'b0;
      r_acc         <= 32'sd0;
      r_best_score  <= 32'sd0;
      r_best_idx    <= 32'hFFFF_FFFF;
      r_b           <= 7'd0;
      r_sq          <= 6'd0;
    end else begin
      if (w_wr_ok) begin
        case (slave_address)
          REG_BOARD_BASE:  r_board_base <= slave_writedata;
          REG_COUNT:       r_count <= (slave_writedata > MAX_BOARDS) ? 7'(MAX_BOARDS)
                                                                     : slave_writedata[6:0];
          REG_RESULT_BASE: r_result_base <= slave_writedata;
          REG_SIDE:        r_side <= slave_writedata[0];
          default: ;
        endcase
      end
      if (w_start) begin
        r_acc        <= 32'sd0;
        r_best_score <= 32'sd0;
        r_best_idx   <= 32'hFFFF_FFFF;
        r_b          <= 7'd0;
        r_sq         <= 6'd0;
      end
      if (r_state == StRdWait && master_readdatavalid) begin
        r_acc <= r_acc + 32'(w_value);
        r_sq  <= r_sq + 6'd1;
      end
      if (r_state == StNext) begin
        if (w_better) begin
          r_best_score <= r_acc;
          r_best_idx   <= 32'(r_b);
        end
        r_b   <= r_b + 7'd1;
        r_sq  <= 6'd0;
        r_acc <= 32'sd0;
      end
    end
  end

endmodule

// File: tb/tb_board_scorer.sv
// Randomized bench for board_scorer: SDRAM model with random stalls/latency and a material model.
module tb_board_scorer;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        slave_waitrequest;
  logic [3:0]  slave_address = 4'h0;
  logic        slave_read = 1'b0;
  logic [31:0] slave_readdata;
  logic        slave_write = 1'b0;
  logic [31:0] slave_writedata = 32'h0;
  logic        master_waitrequest = 1'b0;
  logic [31:0] master_address;
  logic        master_read;
  logic [31:0] master_readdata = 32'h0;
  logic        master_readdatavalid = 1'b0;
  logic        master_write;
  logic [31:0] master_writedata;

  localparam int LIMIT = 30000;

  board_scorer #(.MAX_BOARDS(64), .SQUARES(64)) dut (
    .clk                  (clk),
    .rst                  (rst),
    .slave_waitrequest    (slave_waitrequest),
    .slave_address        (slave_address),
    .slave_read           (slave_read),
    .slave_readdata       (slave_readdata),
    .slave_write          (slave_write),
    .slave_writedata      (slave_writedata),
    .master_waitrequest   (master_waitrequest),
    .master_address       (master_address),
    .master_read          (master_read),
    .master_readdata      (master_readdata),
    .master_readdatavalid (master_readdatavalid),
    .master_write         (master_write),
    .master_writedata     (master_writedata)
  );

  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // ---------------- SDRAM model ----------------
  logic [7:0]  mem [logic [31:0]];
  logic [31:0] res [logic [31:0]];
  typedef struct { int due; logic [7:0] data; } rd_t;
  rd_t pend[$];
  bit  stall_en = 1'b0;
  int  lat_max  = 0;
  int  cyc = 0;
  int  strobe_cnt = 0, both_cnt = 0, unstable_cnt = 0;
  logic        prev_stall_rd = 1'b0, prev_stall_wr = 1'b0;
  logic [31:0] prev_addr = 32'h0, prev_wdata = 32'h0;

  function automatic logic [7:0] rd_mem(input logic [31:0] a);
    return mem.exists(a) ? mem[a] : 8'h00;
  endfunction

  initial begin : sdram
    forever begin
      @(negedge clk);
      cyc++;
      if (rst) begin
        pend.delete();
        master_readdatavalid = 1'b0;
        master_waitrequest   = 1'b0;
        prev_stall_rd        = 1'b0;
        prev_stall_wr        = 1'b0;
        continue;
      end
      if (prev_stall_rd && (!master_read || master_address != prev_addr)) unstable_cnt++;
      if (prev_stall_wr && (!master_write || master_address != prev_addr ||
                            master_writedata != prev_wdata)) unstable_cnt++;
      if (master_read && master_write) both_cnt++;
      if (master_read || master_write) strobe_cnt++;
      master_readdatavalid = 1'b0;
      if (pend.size() > 0 && pend[0].due <= cyc) begin
        master_readdatavalid = 1'b1;
        master_readdata      = {24'($urandom()), pend[0].data};
        void'(pend.pop_front());
      end
      master_waitrequest = stall_en ? ($urandom_range(0, 1) == 1) : 1'b0;
      prev_stall_rd = master_read && master_waitrequest;
      prev_stall_wr = master_write && master_waitrequest;
      prev_addr     = master_address;
      prev_wdata    = master_writedata;
      if (master_read && !master_waitrequest)
        pend.push_back('{cyc + 1 + $urandom_range(0, lat_max), rd_mem(master_address)});
      if (master_write && !master_waitrequest) res[master_address] = master_writedata;
    end
  end

  // ---------------- reference model ----------------
  function automatic int piece_cp(input int code);
    int m = (code < 0) ? -code : code;
    int v;
    if (m == 0 || m > 48) v = 0;
    else if (m <= 8)      v = 100;
    else if (m <= 18)     v = 500;
    else if (m <= 28)     v = 320;
    else if (m <= 38)     v = 330;
    else if (m <= 47)     v = 900;
    else                  v = 0;
    return (code < 0) ? -v : v;
  endfunction

  function automatic int board_score(input logic [31:0] base);
    int s = 0;
    for (int sq = 0; sq < 64; sq++) begin
      int c = $signed(rd_mem(base + 32'(sq)));
      s += piece_cp(c);
    end
    return s;
  endfunction

  task automatic load_board(input logic [31:0] base, input int codes[64]);
    for (int sq = 0; sq < 64; sq++) mem[base + 32'(sq)] = 8'(codes[sq]);
  endtask

  task automatic rand_board(input logic [31:0] base);
    for (int sq = 0; sq < 64; sq++)
      mem[base + 32'(sq)] = ($urandom_range(0, 1) == 1) ? 8'($urandom()) : 8'h00;
  endtask

  // ---------------- slave access ----------------
  task automatic reg_wr(input logic [3:0] a, input logic [31:0] d);
    int i = 0;
    @(negedge clk);
    slave_address = a; slave_writedata = d; slave_write = 1'b1;
    #1;
    while (slave_waitrequest && i < LIMIT) begin
      @(negedge clk); #1; i++;
    end
    check($sformatf("wr%0d_bound", a), {31'h0, slave_waitrequest}, 32'h0);
    @(posedge clk); #1;
    slave_write = 1'b0;
  endtask

  task automatic reg_rd(input logic [3:0] a, output logic [31:0] d, output int waits);
    waits = 0;
    @(negedge clk);
    slave_address = a; slave_read = 1'b1;
    #1;
    while (slave_waitrequest && waits < LIMIT) begin
      @(negedge clk); #1; waits++;
    end
    check($sformatf("rd%0d_bound", a), {31'h0, slave_waitrequest}, 32'h0);
    d = slave_readdata;
    @(posedge clk); #1;
    slave_read = 1'b0;
  endtask

  task automatic configure(input logic [31:0] bb, input int n, input logic [31:0] rb,
                           input bit side);
    res.delete();
    strobe_cnt = 0; both_cnt = 0; unstable_cnt = 0;
    reg_wr(4'd1, bb);
    reg_wr(4'd2, 32'(n));
    reg_wr(4'd3, rb);
    reg_wr(4'd4, {31'h0, side});
  endtask

  task automatic run_job(input string tag, input logic [31:0] bb, input int n,
                         input logic [31:0] rb, input bit side);
    logic [31:0] idx, bs, got;
    int waits, best, exp_idx;
    int sc[$];
    configure(bb, n, rb, side);
    reg_wr(4'd0, 32'h0);
    reg_rd(4'd0, idx, waits);
    reg_rd(4'd5, bs, waits);
    for (int b = 0; b < n; b++) sc.push_back(board_score(bb + 32'(64 * b)));
    best = 0; exp_idx = -1;
    if (n > 0) begin
      best = sc[0];
      foreach (sc[k]) best = side ? ((sc[k] < best) ? sc[k] : best)
                                  : ((sc[k] > best) ? sc[k] : best);
      for (int k = n - 1; k >= 0; k--) if (sc[k] == best) exp_idx = k;
    end
    for (int b = 0; b < n; b++) begin
      got = res.exists(rb + 32'(4 * b)) ? res[rb + 32'(4 * b)] : 32'hDEAD_BEEF;
      check($sformatf("%s_score%0d", tag, b), got, 32'(sc[b]));
    end
    check({tag, "_nres"}, 32'(res.size()), 32'(n));
    check({tag, "_best_idx"}, idx, 32'(exp_idx));
    check({tag, "_best_score"}, bs, 32'(best));
    check({tag, "_rw_excl"}, 32'(both_cnt), 32'h0);
    check({tag, "_stall_stable"}, 32'(unstable_cnt), 32'h0);
  endtask

  // ---------------- main sequence ----------------
  initial begin : main
    int sb[64];
    int z[64];
    logic [31:0] d;
    int waits;
    logic [31:0] got;

    #2 rst = 1'b1;
    #1;
    check("rst_waitreq", {31'h0, slave_waitrequest}, 32'h1);
    check("rst_mread", {31'h0, master_read}, 32'h0);
    check("rst_mwrite", {31'h0, master_write}, 32'h0);
    check("rst_maddr", master_address, 32'h0);
    check("rst_mwdata", master_writedata, 32'h0);
    repeat (3) @(posedge clk);
    @(negedge clk) rst = 1'b0;
    reg_rd(4'd6, d, waits);
    check("rst_best_idx", d, 32'hFFFF_FFFF);
    reg_rd(4'd5, d, waits);
    check("rst_best_score", d, 32'h0);

    reg_wr(4'd2, 32'd100);
    reg_rd(4'd2, d, waits);
    check("count_clamp", d, 32'd64);

    // standard starting position
    foreach (z[i]) z[i] = 0;
    sb = z;
    sb[0] = 9;  sb[1] = 19; sb[2] = 29; sb[3] = 39; sb[4] = 48; sb[5] = 30; sb[6] = 20; sb[7] = 10;
    for (int i = 0; i < 8; i++) begin
      sb[8 + i]  = 1 + i;
      sb[48 + i] = -(1 + i);
      sb[56 + i] = -sb[i];
    end
    load_board(32'h1000, sb);
    run_job("start", 32'h1000, 1, 32'h8000, 1'b0);
    got = res.exists(32'h8000) ? res[32'h8000] : 32'hDEAD_BEEF;
    check("start_word_zero", got, 32'h0);

    sb[59] = 0;
    load_board(32'h1000, sb);
    run_job("noqueen", 32'h1000, 1, 32'h8000, 1'b0);
    got = res.exists(32'h8000) ? res[32'h8000] : 32'hDEAD_BEEF;
    check("noqueen_900", got, 32'd900);

    // +100, -330, +100
    sb = z; sb[12] = 3;   load_board(32'h2000, sb);
    sb = z; sb[40] = -29; load_board(32'h2040, sb);
    sb = z; sb[20] = 5;   load_board(32'h2080, sb);
    run_job("tie_max", 32'h2000, 3, 32'h9000, 1'b0);
    reg_rd(4'd6, d, waits);
    check("tie_max_idx0", d, 32'h0);
    run_job("tie_min", 32'h2000, 3, 32'h9000, 1'b1);
    reg_rd(4'd6, d, waits);
    check("tie_min_idx1", d, 32'h1);

    // empty job
    configure(32'h2000, 0, 32'h9000, 1'b0);
    reg_wr(4'd0, 32'h0);
    reg_rd(4'd0, d, waits);
    check("zero_idx", d, 32'hFFFF_FFFF);
    check("zero_fast", {31'h0, waits <= 3}, 32'h1);
    reg_rd(4'd5, d, waits);
    check("zero_score", d, 32'h0);
    check("zero_no_strobe", 32'(strobe_cnt), 32'h0);

    // random boards, first without then with stalls and latency; board window wraps address 0
    for (int r = 0; r < 4; r++) rand_board(32'hFFFF_FF80 + 32'(64 * r));
    stall_en = 1'b0; lat_max = 0;
    run_job("rnd_nostall", 32'hFFFF_FF80, 4, 32'h3000, 1'($urandom_range(0, 1)));
    stall_en = 1'b1; lat_max = 3;
    run_job("rnd_stall", 32'hFFFF_FF80, 4, 32'h3000, 1'($urandom_range(0, 1)));
    for (int k = 0; k < 2; k++) begin
      for (int r = 0; r < 4; r++) rand_board(32'h4000 + 32'(64 * r));
      run_job($sformatf("rnd%0d", k), 32'h4000, 4, 32'h5000 + 32'(k * 16), 1'(k));
    end

    // reset in the middle of the second board
    for (int r = 0; r < 4; r++) rand_board(32'h6000 + 32'(64 * r));
    configure(32'h6000, 4, 32'h7000, 1'b0);
    reg_wr(4'd0, 32'h0);
    waits = 0;
    while (!(res.size() >= 1 && master_read) && waits < LIMIT) begin
      @(negedge clk); waits++;
    end
    check("reached_board2", {31'h0, res.size() >= 1}, 32'h1);
    repeat (5) @(negedge clk);
    #1 rst = 1'b1;
    #1;
    check("mid_rst_waitreq", {31'h0, slave_waitrequest}, 32'h1);
    check("mid_rst_mread", {31'h0, master_read}, 32'h0);
    check("mid_rst_mwrite", {31'h0, master_write}, 32'h0);
    check("mid_rst_maddr", master_address, 32'h0);
    repeat (2) @(posedge clk);
    @(negedge clk) rst = 1'b0;
    reg_rd(4'd6, d, waits);
    check("mid_rst_best_idx", d, 32'hFFFF_FFFF);
    reg_rd(4'd2, d, waits);
    check("mid_rst_count", d, 32'h0);
    run_job("restart", 32'h6000, 4, 32'h7000, 1'b0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
